time_counter: RTL and testbench
===============================

Name: time_counter

Overview:
Timekeeping core directly upstream of time_displayer. It counts seconds, minutes and hours from a 1 Hz enable pulse. It supports manual hour/minute setting through a mode/increment button pair. It drives the raw sec/min/hour values (binary, WIDTH wide) that time_displayer converts to 7-segment data, and emits an hourly chime pulse.

Parameters:
WIDTH, 32, width of each time output bus (matches time_displayer WIDTH)
SEC_MAX, 59, last seconds value before wrap
MIN_MAX, 59, last minutes value before wrap
HOUR_MAX, 23, last hours value before wrap

Ports:
clk_src  input  1  system clock (single clock domain); all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
tick  input  1  one-cycle 1 Hz enable pulse from the clock divider
btn_mode  input  1  debounced mode button level, active-high
btn_inc  input  1  debounced increment button level, active-high
sec_data  output  WIDTH  current seconds, binary 0..SEC_MAX, upper bits zero
min_data  output  WIDTH  current minutes, binary 0..MIN_MAX, upper bits zero
hour_data  output  WIDTH  current hours, binary 0..HOUR_MAX, upper bits zero
set_mode  output  2  current mode: 00 RUN, 01 SET_HOUR, 10 SET_MIN
chime  output  1  one-cycle pulse on hour rollover in RUN

Behaviour:
- Reset (rst_n low, async): sec/min/hour = 0, set_mode = RUN, chime = 0, button history regs = 1.
- Edge detect: mode_edge = btn_mode & ~btn_mode_q; same for inc_edge. History regs reset to 1, so a button held through reset produces no edge until it is released and pressed again.
- All outputs are registered. An event sampled on edge N is visible on the outputs after edge N (latency 1 clock).
- FSM transitions:
  - RUN -> SET_HOUR on mode_edge
  - SET_HOUR -> SET_MIN on mode_edge
  - SET_MIN -> RUN on mode_edge
  - No other transitions; encoding 11 is unreachable and recovers to RUN on the next clock.
- RUN:
  - On tick, sec increments.
  - sec == SEC_MAX -> sec = 0, min increments.
  - min == MIN_MAX with sec wrap -> min = 0, hour increments and chime = 1 for exactly that cycle.
  - hour == HOUR_MAX with full wrap -> hour = 0 (23:59:59 -> 00:00:00, chime asserted).
  - inc_edge is ignored.
- Entering SET_HOUR: sec forced to 0 on the transition edge. tick is ignored in SET_HOUR and SET_MIN (time frozen).
- SET_HOUR: inc_edge -> hour = (hour == HOUR_MAX) ? 0 : hour+1. No carry to or from other fields; chime stays 0.
- SET_MIN: inc_edge -> min = (min == MIN_MAX) ? 0 : min+1. No carry into hour; chime stays 0.
- Leaving SET_MIN to RUN: counting resumes from sec 0 on the next tick.
- Simultaneous events:
  - mode_edge and tick in RUN: the mode change wins; sec = 0 and no carry or chime occurs.
  - mode_edge and inc_edge in SET_*: the increment applies to the current field, then the mode advances.
  - tick high on consecutive cycles is treated as separate ticks (no pulse-width check).
- Reset mid-operation: all state returns to reset values immediately; no partial carry survives.
- Arithmetic: internal counters are 6 bits (sec/min) and 5 bits (hour), zero-extended to WIDTH. Values above MAX never occur; if forced above MAX they wrap to 0 on the next increment.

Decomposition:
- Shared package time_pkg: mode encoding constants (MODE_RUN, MODE_SET_HOUR, MODE_SET_MIN) and the default SEC_MAX/MIN_MAX/HOUR_MAX constants, shared with time_displayer and future alarm logic.
- Sub-module mod_counter (parameters MAX, CW): enable, load-zero, count, and a carry output that is high when enabled and at MAX. It is instantiated three times, with the carry chained from sec to min to hour in RUN.
- Edge detection and the FSM stay in time_counter.

Test Plan:
- Release reset, apply 60 ticks -> sec sequence 0..59 then 0, min = 1, chime stays 0.
- Preload 23:59:58 through SET mode, return to RUN, apply 2 ticks -> second tick gives 00:00:00 with chime high for exactly 1 cycle.
- Press mode once, press inc 25 times -> set_mode = 01, hour wraps 0..23 and ends at 1; ticks ignored, sec = 0 throughout.
- Mode to SET_MIN at min = 59, inc once -> min = 0, hour unchanged; mode again -> RUN, next tick gives sec = 1.
- Assert tick and the btn_mode rising edge in the same cycle at sec = 30 -> set_mode = 01, sec = 0, no carry.
- Assert rst_n low asynchronously mid-count at 12:34:56 -> outputs go to 0 before the next clock edge. Then hold btn_mode high through reset release -> no mode change until the button is released and pressed again.

Source files
------------

// File: rtl/time_pkg.sv
// Shared timekeeping definitions: mode encoding and default field limits,
// common to time_counter, time_displayer and alarm logic.
package time_pkg;

   localparam logic [1:0] MODE_RUN      = 2'b00;
   localparam logic [1:0] MODE_SET_HOUR = 2'b01;
   localparam logic [1:0] MODE_SET_MIN  = 2'b10;

   typedef enum logic [1:0] {
      ModeRun     = MODE_RUN,
      ModeSetHour = MODE_SET_HOUR,
      ModeSetMin  = MODE_SET_MIN,
      ModeBad     = 2'b11
   } mode_e;

   localparam int unsigned DEFAULT_SEC_MAX  = 59;
   localparam int unsigned DEFAULT_MIN_MAX  = 59;
   localparam int unsigned DEFAULT_HOUR_MAX = 23;

   localparam int unsigned SEC_CW  = 6;
   localparam int unsigned MIN_CW  = 6;
   localparam int unsigned HOUR_CW = 5;

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) counter with synchronous clear; carry flags an enabled
// step taken from MAX so counters can be chained.
module mod_counter #(
   parameter int unsigned MAX = 59,
   parameter int unsigned CW  = 6
) (
   input  logic          clk_src,
   input  logic          rst_n,
   input  logic          en,
   input  logic          clr,
   output logic [CW-1:0] count,
   output logic          carry
);

   logic [CW-1:0] count_q, count_d;

   // Values above MAX can only appear if forced; they wrap to 0 on the next step.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = (count_q >= CW'(MAX)) ? '0 : count_q + CW'(1);
      end
   end

   always_ff @(posedge clk_src or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign carry = en & ~clr & (count_q == CW'(MAX));

endmodule

// File: rtl/time_counter.sv
// Seconds/minutes/hours timekeeper with mode/increment setting and an hourly
// chime pulse; feeds raw binary fields to time_displayer.
module time_counter
   import time_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned SEC_MAX  = DEFAULT_SEC_MAX,
   parameter int unsigned MIN_MAX  = DEFAULT_MIN_MAX,
   parameter int unsigned HOUR_MAX = DEFAULT_HOUR_MAX
) (
   input  logic             clk_src,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             btn_mode,
   input  logic             btn_inc,
   output logic [WIDTH-1:0] sec_data,
   output logic [WIDTH-1:0] min_data,
   output logic [WIDTH-1:0] hour_data,
   output logic [1:0]       set_mode,
   output logic             chime
);

   mode_e mode_q, mode_d;

   logic btn_mode_q, btn_inc_q;
   logic mode_edge, inc_edge;
   logic run;
   logic sec_en, sec_clr, min_en, hour_en;
   logic sec_carry, min_carry, unused_hour_carry;
   logic chime_q;

   logic [SEC_CW-1:0]  sec_cnt;
   logic [MIN_CW-1:0]  min_cnt;
   logic [HOUR_CW-1:0] hour_cnt;

   // History resets high so a button held through reset yields no edge.
   assign mode_edge = btn_mode & ~btn_mode_q;
   assign inc_edge  = btn_inc & ~btn_inc_q;
   assign run       = (mode_q == ModeRun);

   always_comb begin
      mode_d = mode_q;
      case (mode_q)
         ModeRun:     if (mode_edge) mode_d = ModeSetHour;
         ModeSetHour: if (mode_edge) mode_d = ModeSetMin;
         ModeSetMin:  if (mode_edge) mode_d = ModeRun;
         default:     mode_d = ModeRun;
      endcase
   end

   // A mode press in RUN beats a coincident tick: seconds clear, nothing carries.
   assign sec_clr = run & mode_edge;
   assign sec_en  = run & tick & ~mode_edge;
   assign min_en  = (run & sec_carry) | ((mode_q == ModeSetMin) & inc_edge);
   assign hour_en = (run & min_carry) | ((mode_q == ModeSetHour) & inc_edge);

   always_ff @(posedge clk_src or negedge rst_n) begin
      if (!rst_n) begin
         btn_mode_q <= 1'b1;
         btn_inc_q  <= 1'b1;
         mode_q     <= ModeRun;
         chime_q    <= 1'b0;
      end else begin
         btn_mode_q <= btn_mode;
         btn_inc_q  <= btn_inc;
         mode_q     <= mode_d;
         chime_q    <= run & min_carry;
      end
   end

   mod_counter #(
      .MAX (SEC_MAX),
      .CW  (SEC_CW)
   ) u_sec (
      .clk_src (clk_src),
      .rst_n   (rst_n),
      .en      (sec_en),
      .clr     (sec_clr),
      .count   (sec_cnt),
      .carry   (sec_carry)
   );

   mod_counter #(
      .MAX (MIN_MAX),
      .CW  (MIN_CW)
   ) u_min (
      .clk_src (clk_src),
      .rst_n   (rst_n),
      .en      (min_en),
      .clr     (1'b0),
      .count   (min_cnt),
      .carry   (min_carry)
   );

   mod_counter #(
      .MAX (HOUR_MAX),
      .CW  (HOUR_CW)
   ) u_hour (
      .clk_src (clk_src),
      .rst_n   (rst_n),
      .en      (hour_en),
      .clr     (1'b0),
      .count   (hour_cnt),
      .carry   (unused_hour_carry)
   );

   assign sec_data  = WIDTH'(sec_cnt);
   assign min_data  = WIDTH'(min_cnt);
   assign hour_data = WIDTH'(hour_cnt);
   assign set_mode  = mode_q;
   assign chime     = chime_q;

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter: time-of-day reference model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_time_counter;

   localparam int unsigned WIDTH = 32;

   logic clk_src  = 1'b0;
   logic rst_n    = 1'b1;
   logic tick     = 1'b0;
   logic btn_mode = 1'b0;
   logic btn_inc  = 1'b0;

   logic [WIDTH-1:0] sec_data, min_data, hour_data;
   logic [1:0]       set_mode;
   logic             chime;

   time_counter #(
      .WIDTH    (WIDTH),
      .SEC_MAX  (59),
      .MIN_MAX  (59),
      .HOUR_MAX (23)
   ) dut (
      .clk_src   (clk_src),
      .rst_n     (rst_n),
      .tick      (tick),
      .btn_mode  (btn_mode),
      .btn_inc   (btn_inc),
      .sec_data  (sec_data),
      .min_data  (min_data),
      .hour_data (hour_data),
      .set_mode  (set_mode),
      .chime     (chime)
   );

   always #5 clk_src = ~clk_src;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: time of day as seconds-since-midnight arithmetic.
   int m_sec, m_min, m_hour, m_mode;
   bit m_chime, m_pm, m_pi;

   function automatic int next_tod(input int h, input int m, input int s);
      return (h * 3600 + m * 60 + s + 1) % 86400;
   endfunction

   always @(posedge clk_src or negedge rst_n) begin
      if (!rst_n) begin
         m_sec   <= 0;
         m_min   <= 0;
         m_hour  <= 0;
         m_mode  <= 0;
         m_chime <= 1'b0;
         m_pm    <= 1'b1;
         m_pi    <= 1'b1;
      end else begin
         m_pm    <= btn_mode;
         m_pi    <= btn_inc;
         m_chime <= 1'b0;
         case (m_mode)
            0: begin
               if (btn_mode && !m_pm) begin
                  m_mode <= 1;
                  m_sec  <= 0;
               end else if (tick) begin
                  m_sec   <= next_tod(m_hour, m_min, m_sec) % 60;
                  m_min   <= (next_tod(m_hour, m_min, m_sec) / 60) % 60;
                  m_hour  <= next_tod(m_hour, m_min, m_sec) / 3600;
                  m_chime <= (next_tod(m_hour, m_min, m_sec) % 3600) == 0;
               end
            end
            1: begin
               if (btn_inc && !m_pi) m_hour <= (m_hour + 1) % 24;
               if (btn_mode && !m_pm) m_mode <= 2;
            end
            2: begin
               if (btn_inc && !m_pi) m_min <= (m_min + 1) % 60;
               if (btn_mode && !m_pm) m_mode <= 0;
            end
            default: m_mode <= 0;
         endcase
      end
   end

   // Literal expectations posted by the stimulus, checked at the next falling edge.
   string lit_name;
   int    lit_h, lit_m, lit_s, lit_mode, lit_chime;
   int    lit_seq  = 0;
   int    lit_seen = 0;

   always @(negedge clk_src) begin
      vectors++;
      if (sec_data !== WIDTH'(m_sec) || min_data !== WIDTH'(m_min) ||
          hour_data !== WIDTH'(m_hour) || set_mode !== 2'(m_mode) || chime !== m_chime) begin
         miscompares++;
         $display("FAIL model_cycle t=%0t got %0d:%0d:%0d mode=%0d chime=%0d want %0d:%0d:%0d mode=%0d chime=%0d",
                  $time, hour_data, min_data, sec_data, set_mode, chime,
                  m_hour, m_min, m_sec, m_mode, m_chime);
      end
      if (lit_seq != lit_seen) begin
         lit_seen = lit_seq;
         vectors++;
         if (sec_data !== WIDTH'(lit_s) || min_data !== WIDTH'(lit_m) ||
             hour_data !== WIDTH'(lit_h) || set_mode !== 2'(lit_mode) ||
             chime !== 1'(lit_chime)) begin
            miscompares++;
            $display("FAIL %s t=%0t got %0d:%0d:%0d mode=%0d chime=%0d want %0d:%0d:%0d mode=%0d chime=%0d",
                     lit_name, $time, hour_data, min_data, sec_data, set_mode, chime,
                     lit_h, lit_m, lit_s, lit_mode, lit_chime);
         end
      end
   end

   task automatic cycle();
      @(posedge clk_src);
      #1;
   endtask

   task automatic expect_lit(input string name, input int h, input int m, input int s,
                             input int mode, input int ch);
      lit_name  = name;
      lit_h     = h;
      lit_m     = m;
      lit_s     = s;
      lit_mode  = mode;
      lit_chime = ch;
      lit_seq++;
   endtask

   task automatic press_mode();
      btn_mode = 1'b1;
      cycle();
      btn_mode = 1'b0;
      cycle();
   endtask

   task automatic press_inc();
      btn_inc = 1'b1;
      cycle();
      btn_inc = 1'b0;
      cycle();
   endtask

   initial begin
      #1 rst_n = 1'b0;
      cycle();
      cycle();
      expect_lit("reset_state", 0, 0, 0, 0, 0);
      cycle();
      #3 rst_n = 1'b1;
      cycle();

      // 60 back-to-back ticks: seconds run 1..59, wrap, minute carries.
      tick = 1'b1;
      for (int i = 1; i <= 60; i++) begin
         cycle();
         if (i == 30) expect_lit("tick_30", 0, 0, 30, 0, 0);
      end
      tick = 1'b0;
      expect_lit("sec_wrap_min1", 0, 1, 0, 0, 0);
      cycle();

      // Preload 23:59 through the set modes, then count to 23:59:58.
      press_mode();
      expect_lit("enter_set_hour", 0, 1, 0, 1, 0);
      repeat (23) press_inc();
      expect_lit("set_hour_23", 23, 1, 0, 1, 0);
      press_mode();
      repeat (58) press_inc();
      expect_lit("set_min_59", 23, 59, 0, 2, 0);
      press_mode();
      tick = 1'b1;
      repeat (58) cycle();
      tick = 1'b0;
      expect_lit("preload_235958", 23, 59, 58, 0, 0);
      cycle();
      tick = 1'b1;
      cycle();
      cycle();
      tick = 1'b0;
      expect_lit("midnight_chime", 0, 0, 0, 0, 1);
      cycle();
      expect_lit("chime_one_cycle", 0, 0, 0, 0, 0);
      cycle();

      // SET_HOUR with ticks held high: time frozen, hour wraps 23 -> 0.
      tick = 1'b1;
      press_mode();
      repeat (25) press_inc();
      expect_lit("hour_wrap_25", 1, 0, 0, 1, 0);
      tick = 1'b0;
      cycle();

      // SET_MIN wrap does not carry into hour.
      press_mode();
      repeat (59) press_inc();
      expect_lit("min_59", 1, 59, 0, 2, 0);
      press_inc();
      expect_lit("min_wrap_no_carry", 1, 0, 0, 2, 0);
      press_mode();
      expect_lit("back_to_run", 1, 0, 0, 0, 0);
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      expect_lit("resume_sec1", 1, 0, 1, 0, 0);
      cycle();

      // Tick and mode press together at sec 30: mode wins.
      tick = 1'b1;
      repeat (29) cycle();
      tick = 1'b0;
      expect_lit("sec_30", 1, 0, 30, 0, 0);
      cycle();
      tick     = 1'b1;
      btn_mode = 1'b1;
      cycle();
      tick     = 1'b0;
      btn_mode = 1'b0;
      expect_lit("mode_beats_tick", 1, 0, 0, 1, 0);
      cycle();

      // Increment and mode together in SET_HOUR: increment first, then advance.
      btn_mode = 1'b1;
      btn_inc  = 1'b1;
      cycle();
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      expect_lit("inc_then_mode", 2, 0, 0, 2, 0);
      cycle();

      // Build 12:34:56.
      press_mode();
      press_mode();
      repeat (10) press_inc();
      press_mode();
      repeat (34) press_inc();
      press_mode();
      tick = 1'b1;
      repeat (56) cycle();
      tick = 1'b0;
      expect_lit("at_123456", 12, 34, 56, 0, 0);
      cycle();

      // Asynchronous reset between edges, with mode button held through release.
      #1 rst_n = 1'b0;
      expect_lit("async_reset", 0, 0, 0, 0, 0);
      btn_mode = 1'b1;
      cycle();
      cycle();
      #3 rst_n = 1'b1;
      cycle();
      cycle();
      expect_lit("held_btn_no_edge", 0, 0, 0, 0, 0);
      cycle();
      btn_mode = 1'b0;
      cycle();
      btn_mode = 1'b1;
      cycle();
      expect_lit("repress_edge", 0, 0, 0, 1, 0);
      btn_mode = 1'b0;
      cycle();
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
